// File: rtl/apb_cmd_master_pkg.sv
// Shared types and constants for the APB command master.
// Holds the controller FSM encoding and the SPI core register map.
package apb_cmd_master_pkg;

    // Controller state: SETUP is the capture cycle that launches the APB setup
    // phase; ACCESS covers the bus setup phase (PENABLE=0) and the access phase.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        RESP   = 2'b11
    } state_e;

    // SPI core register addresses
    localparam logic [2:0] ADDR_CR1 = 3'b000;
    localparam logic [2:0] ADDR_CR2 = 3'b001;
    localparam logic [2:0] ADDR_BR  = 3'b010;
    localparam logic [2:0] ADDR_SR  = 3'b011;
    localparam logic [2:0] ADDR_DR  = 3'b101;

endpackage

// File: rtl/apb_cmd_master.sv
// APB initiator: turns a valid/ready command stream into APB SETUP/ACCESS
// transfers and returns read data / error status on a valid/ready response.
// One transaction in flight at a time; every output is a flop.
// Optional build macro APB_CMD_MASTER_TIMEOUT_EN adds an ACCESS-phase timeout
// of TIMEOUT_CYCLES wait cycles; without it ACCESS waits forever and
// rsp_timeout is tied low.
module apb_cmd_master
    import apb_cmd_master_pkg::*;
#(
    parameter int unsigned ADDR_W         = 3,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    // command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    // APB initiator port
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    // Elaboration-time sanity check on the timeout length
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_e            r_state;

    // captured command, held while the bus outputs keep their idle values
    logic              r_cmd_write;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [DATA_W-1:0] r_cmd_wdata;

    // registered outputs
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic              r_psel;
    logic              r_penable;
    logic [DATA_W-1:0] r_pwdata;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_rsp_timeout;
    logic              w_timeout_hit;

    // Last permitted wait cycle: PREADY still low here aborts the transfer
    assign w_timeout_hit = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Single FSM: sequences IDLE -> SETUP -> ACCESS -> RESP and owns every output flop
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state       <= IDLE;
            r_cmd_write   <= 1'b0;
            r_cmd_addr    <= '0;
            r_cmd_wdata   <= '0;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_paddr       <= '0;
            r_pwrite      <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwdata      <= '0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_rsp_timeout <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_write <= cmd_write;
                        r_cmd_addr  <= cmd_addr;
                        // reads never put stale data on PWDATA
                        r_cmd_wdata <= cmd_write ? cmd_wdata : '0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= SETUP;
                    end
                end

                SETUP: begin
                    // launch the APB setup phase from the captured command
                    r_psel     <= 1'b1;
                    r_penable  <= 1'b0;
                    r_paddr    <= r_cmd_addr;
                    r_pwrite   <= r_cmd_write;
                    r_pwdata   <= r_cmd_wdata;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    r_state    <= ACCESS;
                end

                ACCESS: begin
                    if (!r_penable) begin
                        // bus setup phase lasts exactly one cycle
                        r_penable <= 1'b1;
                    end else if (PREADY) begin
                        // completing edge: the only place PRDATA/PSLVERR are sampled
                        r_rsp_rdata   <= r_cmd_write ? '0 : PRDATA;
                        r_rsp_err     <= PSLVERR;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                        r_rsp_timeout <= 1'b0;
`endif
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                    end else if (w_timeout_hit) begin
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_wait_cnt    <= r_wait_cnt + 1'b1;
`endif
                    end
                end

                RESP: begin
                    // response fields stay frozen until the consumer takes them
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign PADDR       = r_paddr;
    assign PWRITE      = r_pwrite;
    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWDATA      = r_pwdata;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    assign rsp_timeout = r_rsp_timeout;
`else
    assign rsp_timeout = 1'b0;
`endif

`ifndef SYNTHESIS
    // PENABLE is only ever raised inside a selected transfer
    a_penable_needs_psel: assert property (@(posedge PCLK) disable iff (!PRESETn)
        PENABLE |-> PSEL);
`endif

endmodule
